// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Pure declarations: no timing of its own.
// No flow control involved; consumed by hazard_ctrl and its interface.
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         DMEM_TIMEOUT_DEF = 16;
  localparam int         CNT_W_DEF        = 16;

  // Load in EX writes a real register that the ID instruction reads.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt
  );
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline observations into, and register controls out of, the hazard controller.
// Wires only, zero latency.
// No backpressure: the controller's outputs are themselves the pipeline's stall mechanism.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_RSaddr_i;
  logic [4:0]       IF_ID_RTaddr_i;
  logic             ID_EX_MemRead_i;
  logic [4:0]       ID_EX_RTaddr_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             PCWrite_o;
  logic             IF_ID_Write_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_Write_o;
  logic             ID_EX_Bubble_o;
  logic             EX_MEM_Write_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline side: reports stage contents, receives register controls.
  modport master (
    output IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_MemRead_i, ID_EX_RTaddr_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    input  PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o,
           ID_EX_Bubble_o, EX_MEM_Write_o, err_o, stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_MemRead_i, ID_EX_RTaddr_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    output PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o,
           ID_EX_Bubble_o, EX_MEM_Write_o, err_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Count visible one cycle after the qualifying cycle.
// No backpressure; increments are never dropped except at saturation.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Increment on qualifying cycles, hold once all-ones is reached.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, taken-branch flush, freeze on slow data memory (macro HAZARD_PERF_CNT_EN adds perf counters).
// Controls are combinational from state+inputs (same cycle); err_o and counters update one cycle later.
// Freeze holds every pipeline register while dmem is busy, released by ack or by timeout after DMEM_TIMEOUT cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] wait_q, wait_nxt;
  logic             err_q;
  logic             err_set;
  logic             freeze;
  logic             load_use;

  assign load_use = load_use_hit(hz.ID_EX_MemRead_i, hz.ID_EX_RTaddr_i,
                                 hz.IF_ID_RSaddr_i, hz.IF_ID_RTaddr_i);

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Memory-wait sequencing: decides freeze, next state and timeout.
  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_q;
    err_set   = 1'b0;
    freeze    = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A same-cycle ack is a zero-wait access and never freezes.
        if (hz.dmem_req_i && !hz.dmem_ack_i) begin
          freeze    = 1'b1;
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ack_i) begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else begin
          // The timeout cycle is still frozen; release happens on its edge.
          freeze = 1'b1;
          if (wait_q >= WAIT_LAST) begin
            err_set   = 1'b1;
            state_nxt = ST_RUN;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Register controls by priority: freeze, then load-use stall, then branch flush.
  always_comb begin
    hz.PCWrite_o      = 1'b1;
    hz.IF_ID_Write_o  = 1'b1;
    hz.IF_ID_Flush_o  = 1'b0;
    hz.ID_EX_Write_o  = 1'b1;
    hz.ID_EX_Bubble_o = 1'b0;
    hz.EX_MEM_Write_o = 1'b1;
    if (freeze) begin
      hz.PCWrite_o      = 1'b0;
      hz.IF_ID_Write_o  = 1'b0;
      hz.ID_EX_Write_o  = 1'b0;
      hz.EX_MEM_Write_o = 1'b0;
    end else if (load_use) begin
      // A pending branch is ignored here; it re-resolves next cycle with forwarded data.
      hz.PCWrite_o      = 1'b0;
      hz.IF_ID_Write_o  = 1'b0;
      hz.ID_EX_Bubble_o = 1'b1;
    end else if (hz.branch_taken_i) begin
      hz.IF_ID_Flush_o  = 1'b1;
    end
  end

  assign hz.err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (!hz.PCWrite_o),
    .count_o (hz.stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (hz.IF_ID_Flush_o),
    .count_o (hz.flush_cnt_o)
  );
`else
  assign hz.stall_cnt_o = '0;
  assign hz.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: scoreboard of expected control vectors.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Expected counter values are tracked from the expected control vectors.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // Control vector order: PCWrite, IF_ID_Write, Flush, ID_EX_Write, Bubble, EX_MEM_Write
  localparam logic [5:0] O_IDLE  = 6'b110101;
  localparam logic [5:0] O_FRZ   = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b000111;
  localparam logic [5:0] O_FLUSH = 6'b111101;

  typedef struct {
    string      tag;
    logic [6:0] v;   // {controls, err}
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   m_stall;
  int   m_flush;
  exp_t sb[$];

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.DMEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [6:0] obs();
    return {hz.PCWrite_o, hz.IF_ID_Write_o, hz.IF_ID_Flush_o, hz.ID_EX_Write_o,
            hz.ID_EX_Bubble_o, hz.EX_MEM_Write_o, hz.err_o};
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] lrt, input logic br, input logic req, input logic ack);
    hz.IF_ID_RSaddr_i  = rs;
    hz.IF_ID_RTaddr_i  = rt;
    hz.ID_EX_MemRead_i = mr;
    hz.ID_EX_RTaddr_i  = lrt;
    hz.branch_taken_i  = br;
    hz.dmem_req_i      = req;
    hz.dmem_ack_i      = ack;
  endtask

  // One pipeline cycle: drive inputs, queue the expected controls for that cycle.
  task automatic drive(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] lrt, input logic br,
                       input logic req, input logic ack, input logic [5:0] o, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    set_in(rs, rt, mr, lrt, br, req, ack);
    e.tag = tag;
    e.v   = {o, err};
    sb.push_back(e);
  endtask

  // Asynchronous reset between clock edges; controls must be idle immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check({tag, "/out"}, 32'(obs()), 32'({O_IDLE, 1'b0}));
    check({tag, "/stall_cnt"}, 32'(hz.stall_cnt_o), 32'd0);
    check({tag, "/flush_cnt"}, 32'(hz.flush_cnt_o), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Scoreboard consumer: compares each queued cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_stall = 0;
        m_flush = 0;
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "/out"}, 32'(obs()), 32'(e.v));
`ifdef HAZARD_PERF_CNT_EN
        check({e.tag, "/stall_cnt"}, 32'(hz.stall_cnt_o), 32'(m_stall));
        check({e.tag, "/flush_cnt"}, 32'(hz.flush_cnt_o), 32'(m_flush));
`else
        check({e.tag, "/stall_cnt"}, 32'(hz.stall_cnt_o), 32'd0);
        check({e.tag, "/flush_cnt"}, 32'(hz.flush_cnt_o), 32'd0);
`endif
        if (!e.v[6]) m_stall++;
        if (e.v[4])  m_flush++;
      end
    end
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    m_stall = 0;
    m_flush = 0;
    rst_n   = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    rst_n = 1'b1;

    //     tag         rs     rt     mr    lrt    br    req   ack   expected  err
    drive("idle",      5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // Load-use on rs, then one bubble only
    drive("lu_rs",     5'd5,  5'd0,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_STALL, 1'b0);
    drive("lu_after",  5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // $zero destination never stalls; rt-only match does; non-load never does
    drive("lu_zero",   5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    drive("lu_rt",     5'd3,  5'd7,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_STALL, 1'b0);
    drive("no_load",   5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    drive("lu_miss",   5'd3,  5'd4,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // Memory wait: 3 frozen cycles, ack releases on the 4th
    for (int i = 0; i < 3; i++)
      drive("mw_frz",  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_FRZ,   1'b0);
    drive("mw_ack",    5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, O_IDLE,  1'b0);
    drive("mw_run",    5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // Zero-wait access stays in RUN (following ack=0 cycle is not frozen)
    drive("zw_acc",    5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, O_IDLE,  1'b0);
    drive("zw_after",  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // Freeze outranks load-use; on ack the load-use stall applies
    drive("frz_lu",    5'd9,  5'd0,  1'b1, 5'd9,  1'b1, 1'b1, 1'b0, O_FRZ,   1'b0);
    drive("ack_lu",    5'd9,  5'd0,  1'b1, 5'd9,  1'b1, 1'b1, 1'b1, O_STALL, 1'b0);
    // Timeout: exactly 16 frozen cycles, err rises after the 16th
    for (int i = 0; i < 16; i++)
      drive("to_frz",  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_FRZ,   1'b0);
    drive("to_refrz",  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_FRZ,   1'b1);
    drive("to_ack",    5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, O_IDLE,  1'b1);
    drive("err_stick", 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b1);
    // Reset while in MEM_WAIT with err set
    for (int i = 0; i < 3; i++)
      drive("rst_frz", 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_FRZ,   1'b1);
    do_reset("rst_mw");
    drive("post_rst",  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // Branch with load-use stalls only; branch alone then flushes
    drive("br_lu",     5'd6,  5'd0,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, O_STALL, 1'b0);
    drive("br_flush",  5'd6,  5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, O_FLUSH, 1'b0);
    drive("br_cnt",    5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);
    // Branch during a freeze does not flush
    drive("br_frz",    5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, O_FRZ,   1'b0);
    drive("br_frz_ack",5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, O_IDLE,  1'b0);
    drive("tail",      5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_IDLE,  1'b0);

    // Let the consumer drain the queue, but never wait forever.
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
